// File: rtl/dram_axi_responder.sv
// -----------------------------------------------------------------------------
// dram_axi_responder
//
// AXI4-Lite slave modelling a 256 x 64-bit data DRAM. One transaction is in
// flight at a time. Reads and writes each pass through an accept state, a
// programmable latency countdown and a response state that holds until the
// master takes it. Illegal addresses (misaligned or outside the window
// starting at BASE_ADDR) complete with SLVERR. A bad read returns zero data
// and a bad write leaves memory untouched.
//
// Handshake semantics: a transfer happens on a rising edge where both VALID
// and READY are high. READY outputs are a function of FSM state only and
// never of the same-cycle VALID inputs. Response VALID (R_VALID/B_VALID)
// stays high with stable payload until the matching READY is seen.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   AR_VALID/AR_ADDR/AR_READY     read address channel (17-bit byte address)
//   R_VALID/R_DATA/R_RESP/R_READY read data channel (64-bit, OKAY/SLVERR)
//   AW_VALID/AW_ADDR/AW_READY     write address channel
//   W_VALID/W_DATA/W_READY        write data channel
//   B_VALID/B_RESP/B_READY        write response channel
//
// Optional macro DRAM_LAT_RAND_EN: when defined, a 16-bit Galois LFSR
// (x^16+x^14+x^13+x^11+1, seed 16'hACE1) picks each transaction's latency
// in 1..RD_LAT / 1..WR_LAT. When undefined the latency is fixed.
// -----------------------------------------------------------------------------
module dram_axi_responder #(
  parameter logic [16:0] BASE_ADDR = 17'h10000,
  parameter int unsigned RD_LAT    = 4,
  parameter int unsigned WR_LAT    = 4,
  parameter int unsigned DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AR_VALID,
  input  logic [16:0] AR_ADDR,
  output logic        AR_READY,
  output logic        R_VALID,
  output logic [63:0] R_DATA,
  output logic [1:0]  R_RESP,
  input  logic        R_READY,
  input  logic        AW_VALID,
  input  logic [16:0] AW_ADDR,
  output logic        AW_READY,
  input  logic        W_VALID,
  input  logic [63:0] W_DATA,
  output logic        W_READY,
  output logic        B_VALID,
  output logic [1:0]  B_RESP,
  input  logic        B_READY
);

  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int          CW      = $clog2(MAX_LAT + 1);
  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [31:0] BASE_EXT = 32'(BASE_ADDR);
  localparam logic [31:0] END_EXT  = 32'(BASE_ADDR) + 32'(DEPTH * 8);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ACC, S_RD_LAT, S_RD_DATA,
    S_WR_ACC, S_WR_DATA, S_WR_LAT, S_WR_RESP
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [16:0]    addr_q, addr_d;
  logic [63:0]    r_data_q;
  logic [1:0]     r_resp_q, b_resp_q;
  logic [63:0]    mem_q [DEPTH];

  logic [31:0]    addr_ext;
  logic           addr_ok;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  rd_lat_m1, wr_lat_m1;
  logic           rd_load, wr_load, mem_we;

  // ---------------------------------------------------------------------------
  // Latency selection (latency minus one, i.e. the countdown start value)
  // ---------------------------------------------------------------------------
`ifdef DRAM_LAT_RAND_EN
  logic [15:0] lfsr_q;

  // Right-shifting Galois form; mask 16'hB400 encodes taps 16,14,13,11.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign rd_lat_m1 = CW'(32'(lfsr_q) % RD_LAT);
  assign wr_lat_m1 = CW'(32'(lfsr_q) % WR_LAT);
`else
  assign rd_lat_m1 = CW'(RD_LAT - 1);
  assign wr_lat_m1 = CW'(WR_LAT - 1);
`endif

  // ---------------------------------------------------------------------------
  // Address capture and decode. Decoding the next address (not the latched
  // one) lets a latency-1 read load its data on the same edge the address
  // is captured.
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_d = addr_q;
    if (state_q == S_RD_ACC) addr_d = AR_ADDR;
    if (state_q == S_WR_ACC) addr_d = AW_ADDR;
  end

  assign addr_ext = {15'd0, addr_d};
  assign addr_ok  = (addr_d[2:0] == 3'b000) && (addr_ext >= BASE_EXT) &&
                    (addr_ext < END_EXT);
  assign idx      = IW'((addr_ext - BASE_EXT) >> 3);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. The countdown ends on the edge where the counter
  // reaches zero, which is also the edge that enters the response state;
  // a latency of 1 skips the countdown state entirely.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (AR_VALID)      state_d = S_RD_ACC;
        else if (AW_VALID) state_d = S_WR_ACC;
      end
      S_RD_ACC: begin
        cnt_d   = rd_lat_m1;
        state_d = (rd_lat_m1 == '0) ? S_RD_DATA : S_RD_LAT;
      end
      S_RD_LAT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (R_READY) state_d = S_IDLE;
      end
      S_WR_ACC: begin
        state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        if (W_VALID) begin
          cnt_d   = wr_lat_m1;
          state_d = (wr_lat_m1 == '0) ? S_WR_RESP : S_WR_LAT;
        end
      end
      S_WR_LAT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (B_READY) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    AR_READY = 1'b0;
    AW_READY = 1'b0;
    W_READY  = 1'b0;
    R_VALID  = 1'b0;
    B_VALID  = 1'b0;
    case (state_q)
      S_RD_ACC:  AR_READY = 1'b1;
      S_RD_DATA: R_VALID  = 1'b1;
      S_WR_ACC:  AW_READY = 1'b1;
      S_WR_DATA: W_READY  = 1'b1;
      S_WR_RESP: B_VALID  = 1'b1;
      default: ;
    endcase
    R_DATA = r_data_q;
    R_RESP = r_resp_q;
    B_RESP = b_resp_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath: response payloads are loaded on entry to the response state
  // and cleared on the handshake so they read zero whenever VALID is low.
  // ---------------------------------------------------------------------------
  assign rd_load = (state_d == S_RD_DATA) && (state_q != S_RD_DATA);
  assign wr_load = (state_d == S_WR_RESP) && (state_q != S_WR_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      r_data_q <= '0;
      r_resp_q <= '0;
      b_resp_q <= '0;
    end else begin
      addr_q <= addr_d;
      if (rd_load) begin
        r_data_q <= addr_ok ? mem_q[idx] : 64'h0;
        r_resp_q <= addr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if ((state_q == S_RD_DATA) && R_READY) begin
        r_data_q <= '0;
        r_resp_q <= '0;
      end
      if (wr_load) begin
        b_resp_q <= addr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if ((state_q == S_WR_RESP) && B_READY) begin
        b_resp_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: not reset. A reset coinciding with the W handshake edge aborts
  // the transaction, so the write is suppressed on that edge.
  // ---------------------------------------------------------------------------
  assign mem_we = !rst && (state_q == S_WR_DATA) && W_VALID && addr_ok;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= W_DATA;
  end

endmodule

// File: tb/tb_dram_axi_responder.sv
// -----------------------------------------------------------------------------
// tb_dram_axi_responder: self-checking bench for dram_axi_responder.
// Reference model: a plain array of expected DRAM contents plus the address
// legality rule; responses are predicted from that and queued in exp_q.
// -----------------------------------------------------------------------------
module tb_dram_axi_responder;

  localparam int          RD_LAT = 4;
  localparam int          WR_LAT = 4;
  localparam int          DEPTH  = 256;
  localparam logic [16:0] BASE   = 17'h10000;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        AR_VALID = 0, R_READY = 0, AW_VALID = 0, W_VALID = 0, B_READY = 0;
  logic [16:0] AR_ADDR = '0, AW_ADDR = '0;
  logic [63:0] W_DATA = '0;
  logic        AR_READY, R_VALID, AW_READY, W_READY, B_VALID;
  logic [63:0] R_DATA;
  logic [1:0]  R_RESP, B_RESP;

  always #5 clk = ~clk;

  dram_axi_responder #(.BASE_ADDR(BASE), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // ---------------- reference model / scoreboard ----------------
  logic [63:0] exp_mem [DEPTH];
  logic [65:0] exp_q[$];          // {resp, data} expected for each read

  function automatic bit legal(input logic [16:0] a);
    int ia = int'(a);
    return (ia % 8 == 0) && (ia >= int'(BASE)) && (ia < int'(BASE) + DEPTH * 8);
  endfunction

  function automatic int idx_of(input logic [16:0] a);
    return (int'(a) - int'(BASE)) / 8;
  endfunction

  function automatic logic [1:0] model_write(input logic [16:0] a, input logic [63:0] d);
    if (!legal(a)) return 2'b10;
    exp_mem[idx_of(a)] = d;
    return 2'b00;
  endfunction

  function automatic logic [65:0] model_read(input logic [16:0] a);
    if (!legal(a)) return {2'b10, 64'h0};
    return {2'b00, exp_mem[idx_of(a)]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic axi_read(input logic [16:0] a, input int hold, output logic [63:0] d,
                          output logic [1:0] r, output int lat, output int rdy_len, output bit to);
    int n;
    to = 0; lat = 0; rdy_len = 0; d = '0; r = '0;
    @(negedge clk); AR_VALID = 1; AR_ADDR = a;
    n = 0;
    while (AR_READY !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (AR_READY !== 1'b1) begin to = 1; AR_VALID = 0; return; end
    @(negedge clk); AR_VALID = 0;
    rdy_len = 1 + int'(AR_READY);
    lat = 1;
    while (R_VALID !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    if (R_VALID !== 1'b1) begin to = 1; return; end
    d = R_DATA; r = R_RESP;
    repeat (hold) @(negedge clk);
    R_READY = 1; @(negedge clk); R_READY = 0;
  endtask

  task automatic axi_write(input logic [16:0] a, input logic [63:0] d, input int w_gap,
                           input int hold, output logic [1:0] r, output int lat, output bit to);
    int n;
    to = 0; lat = 0; r = '0;
    @(negedge clk); AW_VALID = 1; AW_ADDR = a;
    n = 0;
    while (AW_READY !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (AW_READY !== 1'b1) begin to = 1; AW_VALID = 0; return; end
    @(negedge clk); AW_VALID = 0;
    repeat (w_gap) @(negedge clk);
    W_VALID = 1; W_DATA = d;
    n = 0;
    while (W_READY !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (W_READY !== 1'b1) begin to = 1; W_VALID = 0; return; end
    @(negedge clk); W_VALID = 0;
    lat = 1;
    while (B_VALID !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    if (B_VALID !== 1'b1) begin to = 1; return; end
    r = B_RESP;
    repeat (hold) @(negedge clk);
    B_READY = 1; @(negedge clk); B_READY = 0;
  endtask

  task automatic do_reset();
    rst = 1; AR_VALID = 0; AW_VALID = 0; W_VALID = 0; R_READY = 0; B_READY = 0;
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_chk++; if ({AR_READY, AW_READY, W_READY} !== 3'b000) $display("FAIL reset_ready: got %b expected 000", {AR_READY, AW_READY, W_READY}); else n_pass++;
    n_chk++; if ({R_VALID, B_VALID} !== 2'b00) $display("FAIL reset_valid: got %b expected 00", {R_VALID, B_VALID}); else n_pass++;
    n_chk++; if ({R_DATA, R_RESP, B_RESP} !== 68'h0) $display("FAIL reset_payload: got %h expected 0", {R_DATA, R_RESP, B_RESP}); else n_pass++;
  endtask

  task automatic test_read_basic();
    logic [63:0] d; logic [1:0] r, er; logic [65:0] e; int lat, rl; bit to;
    er = model_write(17'h10028, 64'h1234560C789ABC1F);
    axi_write(17'h10028, 64'h1234560C789ABC1F, 0, 0, r, lat, to);
    n_chk++; if (to || r !== er) $display("FAIL preload_bresp: got %b to=%0d expected %b", r, to, er); else n_pass++;
    n_chk++; if (lat !== WR_LAT) $display("FAIL preload_blat: got %0d expected %0d", lat, WR_LAT); else n_pass++;
    exp_q.push_back(model_read(17'h10028));
    axi_read(17'h10028, 0, d, r, lat, rl, to);
    e = exp_q.pop_front();
    n_chk++; if (to) $display("FAIL rd_basic_timeout: got timeout expected response"); else n_pass++;
    n_chk++; if (rl !== 1) $display("FAIL ar_ready_width: got %0d cycles expected 1", rl); else n_pass++;
    n_chk++; if (lat !== RD_LAT) $display("FAIL rd_latency: got %0d expected %0d", lat, RD_LAT); else n_pass++;
    n_chk++; if ({r, d} !== e) $display("FAIL rd_basic_data: got %b/%h expected %b/%h", r, d, e[65:64], e[63:0]); else n_pass++;
    n_chk++; if ({R_VALID, R_DATA} !== 65'h0) $display("FAIL rd_drop: got valid=%b data=%h expected 0/0", R_VALID, R_DATA); else n_pass++;
  endtask

  task automatic test_write_read();
    logic [63:0] d, wd; logic [1:0] r, er; logic [65:0] e; int lat, rl; bit to;
    logic [16:0] addrs [2];
    addrs[0] = 17'h107F8; addrs[1] = 17'h10000;
    for (int i = 0; i < 2; i++) begin
      wd = (i == 0) ? 64'hFFF00001AAA55502 : {$urandom, $urandom};
      er = model_write(addrs[i], wd);
      axi_write(addrs[i], wd, i, 0, r, lat, to);
      n_chk++; if (to || r !== er) $display("FAIL wr_bresp[%0d]: got %b to=%0d expected %b", i, r, to, er); else n_pass++;
      n_chk++; if (lat !== WR_LAT) $display("FAIL wr_latency[%0d]: got %0d expected %0d", i, lat, WR_LAT); else n_pass++;
      n_chk++; if (B_VALID !== 1'b0) $display("FAIL b_drop[%0d]: got %b expected 0", i, B_VALID); else n_pass++;
      exp_q.push_back(model_read(addrs[i]));
      axi_read(addrs[i], 0, d, r, lat, rl, to);
      e = exp_q.pop_front();
      n_chk++; if (to || {r, d} !== e) $display("FAIL wr_readback[%0d]: got %b/%h expected %b/%h", i, r, d, e[65:64], e[63:0]); else n_pass++;
    end
  endtask

  task automatic test_errors();
    logic [63:0] d; logic [1:0] r, er; logic [65:0] e; int lat, rl; bit to;
    logic [16:0] bad [4];
    logic [16:0] wbad [2];
    logic [16:0] wvic [2];
    bad[0] = 17'h10804; bad[1] = 17'h10003; bad[2] = 17'h10800; bad[3] = 17'h0FFF8;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model_read(bad[i]));
      axi_read(bad[i], 0, d, r, lat, rl, to);
      e = exp_q.pop_front();
      n_chk++; if (to || {r, d} !== e) $display("FAIL rd_err[%0d]: got %b/%h expected %b/%h", i, r, d, e[65:64], e[63:0]); else n_pass++;
    end
    // Bad writes whose truncated index would alias a real entry.
    wbad[0] = 17'h0FFF8; wvic[0] = 17'h107F8;
    wbad[1] = 17'h10800; wvic[1] = 17'h10000;
    for (int i = 0; i < 2; i++) begin
      er = model_write(wbad[i], 64'hDEADBEEFDEADBEEF);
      axi_write(wbad[i], 64'hDEADBEEFDEADBEEF, 0, 0, r, lat, to);
      n_chk++; if (to || r !== er) $display("FAIL wr_err[%0d]: got %b expected %b", i, r, er); else n_pass++;
      n_chk++; if (lat !== WR_LAT) $display("FAIL wr_err_lat[%0d]: got %0d expected %0d", i, lat, WR_LAT); else n_pass++;
      exp_q.push_back(model_read(wvic[i]));
      axi_read(wvic[i], 0, d, r, lat, rl, to);
      e = exp_q.pop_front();
      n_chk++; if (to || {r, d} !== e) $display("FAIL wr_err_nomod[%0d]: got %b/%h expected %b/%h", i, r, d, e[65:64], e[63:0]); else n_pass++;
    end
  endtask

  task automatic test_priority();
    int cyc, ar_at, h_at, aw_at, n; bit early; logic [63:0] rd, wd; logic [1:0] rr, er; logic [65:0] e;
    ar_at = -1; h_at = -1; aw_at = -1; early = 0; rd = '0; rr = '0;
    wd = {$urandom, $urandom};
    e = model_read(17'h10028);
    @(negedge clk);
    AR_VALID = 1; AR_ADDR = 17'h10028; AW_VALID = 1; AW_ADDR = 17'h10030; R_READY = 1;
    for (cyc = 0; cyc < 60 && aw_at < 0; cyc++) begin
      if (AR_READY === 1'b1 && ar_at < 0) ar_at = cyc;
      if (ar_at >= 0 && cyc > ar_at) AR_VALID = 0;
      if (R_VALID === 1'b1 && h_at < 0) begin h_at = cyc; rd = R_DATA; rr = R_RESP; end
      if (AW_READY === 1'b1) begin aw_at = cyc; if (h_at < 0) early = 1; end
      if (aw_at < 0) @(negedge clk);
    end
    R_READY = 0; AR_VALID = 0;
    n_chk++; if (ar_at < 0 || h_at < 0 || early) $display("FAIL prio_order: got ar=%0d rhs=%0d aw=%0d expected read first", ar_at, h_at, aw_at); else n_pass++;
    n_chk++; if (aw_at !== h_at + 2) $display("FAIL prio_bubble: got aw cycle %0d expected %0d", aw_at, h_at + 2); else n_pass++;
    n_chk++; if ({rr, rd} !== e) $display("FAIL prio_rdata: got %b/%h expected %b/%h", rr, rd, e[65:64], e[63:0]); else n_pass++;
    @(negedge clk); AW_VALID = 0; W_VALID = 1; W_DATA = wd;
    n_chk++; if (W_READY !== 1'b1) $display("FAIL prio_wready: got %b expected 1", W_READY); else n_pass++;
    @(negedge clk); W_VALID = 0;
    er = model_write(17'h10030, wd);
    n = 0;
    while (B_VALID !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_chk++; if (B_VALID !== 1'b1 || B_RESP !== er) $display("FAIL prio_bresp: got valid=%b resp=%b expected 1/%b", B_VALID, B_RESP, er); else n_pass++;
    B_READY = 1; @(negedge clk); B_READY = 0;
  endtask

  task automatic test_stall();
    logic [65:0] e; int n; bit bad;
    e = model_read(17'h10028);
    @(negedge clk); AR_VALID = 1; AR_ADDR = 17'h10028;
    n = 0;
    while (AR_READY !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    @(negedge clk); AR_VALID = 0;
    n = 0;
    while (R_VALID !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_chk++; if (R_VALID !== 1'b1) $display("FAIL stall_timeout: got no R_VALID expected 1"); else n_pass++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (R_VALID !== 1'b1 || {R_RESP, R_DATA} !== e) bad = 1;
      @(negedge clk);
    end
    n_chk++; if (bad) $display("FAIL stall_stable: got unstable R channel expected %h held", e); else n_pass++;
    n_chk++; if (R_VALID !== 1'b1 || {R_RESP, R_DATA} !== e) $display("FAIL stall_cycle11: got %b/%h expected 1/%h", R_VALID, {R_RESP, R_DATA}, e); else n_pass++;
    R_READY = 1; @(negedge clk); R_READY = 0;
    n_chk++; if ({R_VALID, R_DATA, R_RESP} !== 67'h0) $display("FAIL stall_end: got %b/%h expected 0/0", R_VALID, R_DATA); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] d, p, q; logic [1:0] r, er; logic [65:0] e; int lat, rl, n; bit to, seen;
    // Reset during the write latency: the write has landed already.
    p = {$urandom, $urandom}; q = {$urandom, $urandom};
    er = model_write(17'h10038, p);
    axi_write(17'h10038, p, 0, 0, r, lat, to);
    @(negedge clk); AW_VALID = 1; AW_ADDR = 17'h10038;
    n = 0;
    while (AW_READY !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    @(negedge clk); AW_VALID = 0; W_VALID = 1; W_DATA = q;
    @(negedge clk); W_VALID = 0;
    @(negedge clk); rst = 1;
    @(negedge clk);
    n_chk++; if ({AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP} !== 72'h0)
      $display("FAIL rst_wrlat_outputs: got %h expected 0", {AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP}); else n_pass++;
    rst = 0;
    er = model_write(17'h10038, q);
    seen = 0;
    repeat (8) begin @(negedge clk); if (B_VALID !== 1'b0) seen = 1; end
    n_chk++; if (seen) $display("FAIL rst_wrlat_abort: got B_VALID after reset expected 0"); else n_pass++;
    exp_q.push_back(model_read(17'h10038));
    axi_read(17'h10038, 0, d, r, lat, rl, to);
    e = exp_q.pop_front();
    n_chk++; if (to || {r, d} !== e) $display("FAIL rst_wrlat_data: got %b/%h expected %b/%h", r, d, e[65:64], e[63:0]); else n_pass++;
    // Reset while waiting for W: memory keeps its old value.
    er = model_write(17'h10040, p);
    axi_write(17'h10040, p, 0, 0, r, lat, to);
    @(negedge clk); AW_VALID = 1; AW_ADDR = 17'h10040;
    n = 0;
    while (AW_READY !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    @(negedge clk); AW_VALID = 0;
    n_chk++; if (W_READY !== 1'b1) $display("FAIL rst_wrdata_wready: got %b expected 1", W_READY); else n_pass++;
    rst = 1;
    @(negedge clk);
    n_chk++; if ({AR_READY, R_VALID, AW_READY, W_READY, B_VALID} !== 5'b0) $display("FAIL rst_wrdata_outputs: got %b expected 00000", {AR_READY, R_VALID, AW_READY, W_READY, B_VALID}); else n_pass++;
    rst = 0;
    exp_q.push_back(model_read(17'h10040));
    axi_read(17'h10040, 0, d, r, lat, rl, to);
    e = exp_q.pop_front();
    n_chk++; if (to || {r, d} !== e) $display("FAIL rst_wrdata_nomod: got %b/%h expected %b/%h", r, d, e[65:64], e[63:0]); else n_pass++;
  endtask

  task automatic test_random();
    logic [16:0] written[$];
    logic [16:0] bad [5];
    logic [16:0] a; logic [63:0] d, wd; logic [1:0] r, er; logic [65:0] e; int lat, rl, op; bit to;
    bad[0] = 17'h0FFF8; bad[1] = 17'h10800; bad[2] = 17'h1FFF8; bad[3] = 17'h00000; bad[4] = 17'h10005;
    for (int i = 0; i < 40; i++) begin
      op = (written.size() == 0) ? 0 : int'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) a = bad[$urandom_range(0, 4)];
      else if (op == 0) a = BASE + 17'($urandom_range(0, DEPTH - 1) * 8);
      else a = written[$urandom_range(0, written.size() - 1)];
      if (op == 0) begin
        wd = {$urandom, $urandom};
        er = model_write(a, wd);
        if (legal(a)) written.push_back(a);
        axi_write(a, wd, $urandom_range(0, 3), $urandom_range(0, 3), r, lat, to);
        n_chk++; if (to || r !== er || lat !== WR_LAT) $display("FAIL rnd_wr[%0d] a=%h: got resp %b lat %0d expected %b/%0d", i, a, r, lat, er, WR_LAT); else n_pass++;
      end else begin
        exp_q.push_back(model_read(a));
        axi_read(a, $urandom_range(0, 3), d, r, lat, rl, to);
        e = exp_q.pop_front();
        n_chk++; if (to || {r, d} !== e || lat !== RD_LAT) $display("FAIL rnd_rd[%0d] a=%h: got %b/%h lat %0d expected %b/%h lat %0d", i, a, r, d, lat, e[65:64], e[63:0], RD_LAT); else n_pass++;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_read_basic();
    test_write_read();
    test_errors();
    test_priority();
    test_stall();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within 500000 time units");
    $fatal(1);
  end

endmodule
